io_interconnect: RTL and testbench
==================================

# io_interconnect

Single-master IO bus bridge between the CPU data port and the memory-mapped peripheral cores (LED, UART, timer, switches). It accepts one CPU load/store at a time and decodes the slave index from the address. It drives a one-cycle strobe with a one-hot chip select to the selected slave, collects read data after a fixed one-cycle slave latency, and returns an ack (or error) to the CPU.

## Interface
- NUM_SLAVES, 4: number of attached slaves, 1..16; slave index = io_cpu_address[11:8].
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- io_cpu_req  in  1  CPU request valid; held stable by CPU until io_cpu_ack.
- io_cpu_we  in  1  1 = write, 0 = read.
- io_cpu_address  in  32  byte address.
- io_cpu_wr_data  in  32  write data.
- io_cpu_ack  out  1  one-cycle completion pulse.
- io_cpu_err  out  1  valid with ack; 1 = unmapped slave.
- io_cpu_rd_data  out  32  read result, valid while ack=1.
- io_bus_m_rd_en  out  1  read strobe to slaves.
- io_bus_m_wr_en  out  1  write strobe to slaves.
- io_bus_m_cs  out  NUM_SLAVES  one-hot chip select.
- io_bus_m_address  out  32  latched CPU address, broadcast.
- io_bus_m_wr_data  out  32  latched CPU write data, broadcast.
- io_bus_m_rd_data  in  32*NUM_SLAVES  slave i read data at bits [32*i+31:32*i]; registered in slave, valid the cycle after its strobe.

## Operation
- FSM states: IDLE, STROBE, CAPTURE, RESP.
- IDLE: if io_cpu_req=1, latch address, wr_data, we, and slave index. Compute err = (index >= NUM_SLAVES). Go to STROBE.
- STROBE, mapped slave: cs[index]=1. Drive wr_en=we and rd_en=~we, each for exactly this cycle. Write goes to RESP; read goes to CAPTURE.
- STROBE, unmapped slave: no cs and no strobes. Go to RESP.
- CAPTURE: register io_bus_m_rd_data slice [index] into the rdata register. Go to RESP.
- RESP: ack=1 for one cycle; err = latched err. Go to IDLE.
- io_cpu_rd_data in RESP:
  - read: the captured data;
  - write or error: 0.
- All io_bus_m_* and io_cpu_* outputs are registered/state-decoded. No combinational path from CPU inputs to any output.
- cs is never multi-hot; rd_en and wr_en are never both 1.
- io_bus_m_address/wr_data hold their latched value outside STROBE. Slaves ignore them unless cs is set.
- io_cpu_req is ignored outside IDLE.
- Address bits other than [11:8] are not checked here. Slaves decode the register offset from [7:0].

## Timing
- Reset values: state=IDLE; ack=0, err=0, rd_data=0, rd_en=0, wr_en=0, cs=0, address=0, wr_data=0.
- Latency, with request sampled at edge N:
  - write: strobe in cycle N+1, ack in cycle N+2;
  - read: strobe N+1, capture N+2, ack N+3;
  - unmapped: ack with err in N+2.
- Back-to-back: a request held high after ack is sampled in the IDLE cycle following RESP. Throughput is 1 write per 3 cycles and 1 read per 4 cycles.
- rst asserted in any state: next cycle is IDLE with all outputs at reset values. An in-flight access is dropped with no ack. A strobe already issued to a slave is not retracted.
- io_cpu_req deasserted mid-transaction: the transaction completes and ack is still issued.

## Test plan
- Write to LED: req, we=1, addr=0x00000100, wdata=0x5 → cycle N+1: cs=4'b0010, wr_en=1, wr_data=0x5. Cycle N+2: ack=1, err=0. No other strobe cycles.
- Read slave 2: slave 2 returns 0xDEADBEEF after its strobe, addr=0x00000204 → rd_en with cs=4'b0100 at N+1. ack at N+3 with rd_data=0xDEADBEEF. Other slave data ignored.
- Unmapped: addr=0x00000500 with NUM_SLAVES=4 → cs=0 and no strobes. ack=1, err=1, rd_data=0 at N+2.
- Back-to-back: write slave 0, then read slave 3 with req held → second strobe one cycle after first ack. Each transaction acks exactly once.
- Reset mid-read: rst in CAPTURE → next cycle IDLE, ack never asserted. A new request afterwards completes normally.
- req dropped after acceptance, or toggled during STROBE → single transaction, single ack, no extra strobe.

Source files
------------

// File: rtl/io_interconnect.sv
// Single-master IO bus bridge: accepts one CPU load/store at a time, strobes the
// addressed slave with a one-hot chip select and returns ack/err plus read data.
module io_interconnect #(
    parameter int NUM_SLAVES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      io_cpu_req,
    input  logic                      io_cpu_we,
    input  logic [31:0]               io_cpu_address,
    input  logic [31:0]               io_cpu_wr_data,
    output logic                      io_cpu_ack,
    output logic                      io_cpu_err,
    output logic [31:0]               io_cpu_rd_data,
    output logic                      io_bus_m_rd_en,
    output logic                      io_bus_m_wr_en,
    output logic [NUM_SLAVES-1:0]     io_bus_m_cs,
    output logic [31:0]               io_bus_m_address,
    output logic [31:0]               io_bus_m_wr_data,
    input  logic [32*NUM_SLAVES-1:0]  io_bus_m_rd_data
);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        CAPTURE,
        RESP
    } state_t;

    state_t      state_reg, state_next;
    logic        we_reg;
    logic        err_reg;
    logic [3:0]  index_reg;
    logic [31:0] address_reg;
    logic [31:0] wr_data_reg;
    logic [31:0] rdata_reg;
    logic        strobe;

    // Full 16-entry view of the slave read buses so the 4-bit index never
    // selects outside the array; absent slaves read as zero.
    logic [31:0] slave_data [16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_slave_data
            if (gi < NUM_SLAVES) begin : g_present
                assign slave_data[gi] = io_bus_m_rd_data[32*gi +: 32];
            end else begin : g_absent
                assign slave_data[gi] = 32'd0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (io_cpu_req) state_next = STROBE;
            STROBE:  state_next = (err_reg || we_reg) ? RESP : CAPTURE;
            CAPTURE: state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg      <= 1'b0;
            err_reg     <= 1'b0;
            index_reg   <= 4'd0;
            address_reg <= 32'd0;
            wr_data_reg <= 32'd0;
            rdata_reg   <= 32'd0;
        end else begin
            if (state_reg == IDLE && io_cpu_req) begin
                we_reg      <= io_cpu_we;
                index_reg   <= io_cpu_address[11:8];
                err_reg     <= {1'b0, io_cpu_address[11:8]} >= 5'(NUM_SLAVES);
                address_reg <= io_cpu_address;
                wr_data_reg <= io_cpu_wr_data;
            end
            if (state_reg == CAPTURE) begin
                rdata_reg <= slave_data[index_reg];
            end
        end
    end

    // Every output is decoded from registered state, never from CPU inputs.
    assign strobe           = (state_reg == STROBE) && !err_reg;
    assign io_bus_m_rd_en   = strobe && !we_reg;
    assign io_bus_m_wr_en   = strobe && we_reg;
    assign io_bus_m_address = address_reg;
    assign io_bus_m_wr_data = wr_data_reg;

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_cs
            assign io_bus_m_cs[gi] = strobe && (index_reg == 4'(gi));
        end
    endgenerate

    assign io_cpu_ack     = (state_reg == RESP);
    assign io_cpu_err     = io_cpu_ack && err_reg;
    assign io_cpu_rd_data = (io_cpu_ack && !we_reg && !err_reg) ? rdata_reg : 32'd0;

endmodule

// File: tb/tb_io_interconnect.sv
// Directed testbench for io_interconnect: registered slave models, per-scenario
// tasks with inline cycle-accurate checks.
module tb_io_interconnect;

    logic         clk;
    logic         rst;
    logic         req;
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         ack;
    logic         err;
    logic [31:0]  rdd;
    logic         rd_en;
    logic         wr_en;
    logic [3:0]   cs;
    logic [31:0]  maddr;
    logic [31:0]  mwdata;
    logic [127:0] bus_rd;

    logic [31:0]  slave_val [4];
    int           checks;
    int           fails;
    int           ack_cnt;
    int           strobe_cnt;

    io_interconnect #(.NUM_SLAVES(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .io_cpu_req       (req),
        .io_cpu_we        (we),
        .io_cpu_address   (addr),
        .io_cpu_wr_data   (wdata),
        .io_cpu_ack       (ack),
        .io_cpu_err       (err),
        .io_cpu_rd_data   (rdd),
        .io_bus_m_rd_en   (rd_en),
        .io_bus_m_wr_en   (wr_en),
        .io_bus_m_cs      (cs),
        .io_bus_m_address (maddr),
        .io_bus_m_wr_data (mwdata),
        .io_bus_m_rd_data (bus_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slaves present data only in the cycle after their own read strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            bus_rd[32*i +: 32] <= (rd_en && cs[i]) ? slave_val[i] : (32'hBAD0_0000 | 32'(i));
        end
    end

    always @(negedge clk) begin
        if (ack) ack_cnt++;
        if (rd_en || wr_en) strobe_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        tick(); tick(); tick();
        checks++; if (ack !== 1'b0) begin fails++; $display("FAIL rst_ack: got %b want 0", ack); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", err); end
        checks++; if (rdd !== 32'd0) begin fails++; $display("FAIL rst_rd_data: got %h want 0", rdd); end
        checks++; if (rd_en !== 1'b0) begin fails++; $display("FAIL rst_rd_en: got %b want 0", rd_en); end
        checks++; if (wr_en !== 1'b0) begin fails++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
        checks++; if (cs !== 4'b0000) begin fails++; $display("FAIL rst_cs: got %b want 0000", cs); end
        checks++; if (maddr !== 32'd0) begin fails++; $display("FAIL rst_address: got %h want 0", maddr); end
        checks++; if (mwdata !== 32'd0) begin fails++; $display("FAIL rst_wr_data: got %h want 0", mwdata); end
        rst = 1'b0;
        tick();
        $display("reset: outputs ack=%b cs=%b address=%h", ack, cs, maddr);
    endtask

    task automatic test_write_led();
        int a0, s0;
        a0 = ack_cnt; s0 = strobe_cnt;
        req = 1'b1; we = 1'b1; addr = 32'h0000_0100; wdata = 32'h5;
        tick();
        checks++; if (cs !== 4'b0010) begin fails++; $display("FAIL wr_cs: got %b want 0010", cs); end
        checks++; if (wr_en !== 1'b1) begin fails++; $display("FAIL wr_wr_en: got %b want 1", wr_en); end
        checks++; if (rd_en !== 1'b0) begin fails++; $display("FAIL wr_rd_en: got %b want 0", rd_en); end
        checks++; if (mwdata !== 32'h5) begin fails++; $display("FAIL wr_wr_data: got %h want 5", mwdata); end
        checks++; if (maddr !== 32'h100) begin fails++; $display("FAIL wr_address: got %h want 100", maddr); end
        checks++; if (ack !== 1'b0) begin fails++; $display("FAIL wr_early_ack: got %b want 0", ack); end
        tick();
        checks++; if (ack !== 1'b1) begin fails++; $display("FAIL wr_ack: got %b want 1", ack); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL wr_err: got %b want 0", err); end
        checks++; if (rdd !== 32'd0) begin fails++; $display("FAIL wr_rd_data: got %h want 0", rdd); end
        checks++; if (wr_en !== 1'b0) begin fails++; $display("FAIL wr_strobe_len: got %b want 0", wr_en); end
        req = 1'b0;
        tick(); tick();
        checks++; if (ack_cnt - a0 !== 1) begin fails++; $display("FAIL wr_ack_count: got %0d want 1", ack_cnt - a0); end
        checks++; if (strobe_cnt - s0 !== 1) begin fails++; $display("FAIL wr_strobe_count: got %0d want 1", strobe_cnt - s0); end
        $display("write led: addr=%h data=%h acks=%0d strobes=%0d", addr, wdata, ack_cnt - a0, strobe_cnt - s0);
    endtask

    task automatic test_read_slave2();
        req = 1'b1; we = 1'b0; addr = 32'h0000_0204; wdata = 32'h0;
        tick();
        checks++; if (rd_en !== 1'b1) begin fails++; $display("FAIL rd_rd_en: got %b want 1", rd_en); end
        checks++; if (wr_en !== 1'b0) begin fails++; $display("FAIL rd_wr_en: got %b want 0", wr_en); end
        checks++; if (cs !== 4'b0100) begin fails++; $display("FAIL rd_cs: got %b want 0100", cs); end
        tick();
        checks++; if (ack !== 1'b0) begin fails++; $display("FAIL rd_early_ack: got %b want 0", ack); end
        checks++; if (rd_en !== 1'b0) begin fails++; $display("FAIL rd_strobe_len: got %b want 0", rd_en); end
        tick();
        checks++; if (ack !== 1'b1) begin fails++; $display("FAIL rd_ack: got %b want 1", ack); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL rd_err: got %b want 0", err); end
        checks++; if (rdd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data: got %h want deadbeef", rdd); end
        req = 1'b0;
        tick();
        checks++; if (rdd !== 32'd0) begin fails++; $display("FAIL rd_data_after: got %h want 0", rdd); end
        $display("read slave2: addr=%h data=%h", addr, 32'hDEAD_BEEF);
    endtask

    task automatic test_unmapped();
        req = 1'b1; we = 1'b0; addr = 32'h0000_0500;
        tick();
        checks++; if (cs !== 4'b0000) begin fails++; $display("FAIL um_cs: got %b want 0000", cs); end
        checks++; if ((rd_en | wr_en) !== 1'b0) begin fails++; $display("FAIL um_strobe: got %b want 0", rd_en | wr_en); end
        tick();
        checks++; if (ack !== 1'b1) begin fails++; $display("FAIL um_ack: got %b want 1", ack); end
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL um_err: got %b want 1", err); end
        checks++; if (rdd !== 32'd0) begin fails++; $display("FAIL um_rd_data: got %h want 0", rdd); end
        req = 1'b0;
        tick();
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL um_err_len: got %b want 0", err); end
        $display("unmapped: addr=%h err reported", addr);
    endtask

    task automatic test_back_to_back();
        int a0, s0;
        a0 = ack_cnt; s0 = strobe_cnt;
        req = 1'b1; we = 1'b1; addr = 32'h0000_0000; wdata = 32'hA5;
        tick();
        checks++; if (cs !== 4'b0001 || wr_en !== 1'b1) begin fails++; $display("FAIL b2b_wr_strobe: got cs=%b wr_en=%b want 0001/1", cs, wr_en); end
        tick();
        checks++; if (ack !== 1'b1) begin fails++; $display("FAIL b2b_wr_ack: got %b want 1", ack); end
        we = 1'b0; addr = 32'h0000_0300;
        tick();
        checks++; if ((ack | rd_en | wr_en) !== 1'b0) begin fails++; $display("FAIL b2b_idle: got ack=%b rd=%b wr=%b want 0", ack, rd_en, wr_en); end
        tick();
        checks++; if (rd_en !== 1'b1 || cs !== 4'b1000) begin fails++; $display("FAIL b2b_rd_strobe: got rd_en=%b cs=%b want 1/1000", rd_en, cs); end
        tick();
        checks++; if (ack !== 1'b0) begin fails++; $display("FAIL b2b_capture_ack: got %b want 0", ack); end
        tick();
        checks++; if (ack !== 1'b1 || rdd !== 32'hCAFE_0003) begin fails++; $display("FAIL b2b_rd_ack: got ack=%b data=%h want 1/cafe0003", ack, rdd); end
        req = 1'b0;
        tick(); tick();
        checks++; if (ack_cnt - a0 !== 2) begin fails++; $display("FAIL b2b_ack_count: got %0d want 2", ack_cnt - a0); end
        checks++; if (strobe_cnt - s0 !== 2) begin fails++; $display("FAIL b2b_strobe_count: got %0d want 2", strobe_cnt - s0); end
        $display("back-to-back: write s0 + read s3, acks=%0d strobes=%0d", ack_cnt - a0, strobe_cnt - s0);
    endtask

    task automatic test_reset_mid_read();
        int a0;
        req = 1'b1; we = 1'b0; addr = 32'h0000_0100;
        tick();
        checks++; if (rd_en !== 1'b1) begin fails++; $display("FAIL mr_rd_en: got %b want 1", rd_en); end
        req = 1'b0;
        tick();
        a0 = ack_cnt;
        rst = 1'b1;
        tick();
        checks++; if (ack !== 1'b0) begin fails++; $display("FAIL mr_ack: got %b want 0", ack); end
        checks++; if (maddr !== 32'd0) begin fails++; $display("FAIL mr_address: got %h want 0", maddr); end
        rst = 1'b0;
        tick(); tick(); tick();
        checks++; if (ack_cnt - a0 !== 0) begin fails++; $display("FAIL mr_no_ack: got %0d want 0", ack_cnt - a0); end
        req = 1'b1; we = 1'b1; addr = 32'h0000_0208; wdata = 32'h77;
        tick();
        checks++; if (cs !== 4'b0100 || wr_en !== 1'b1) begin fails++; $display("FAIL mr_new_strobe: got cs=%b wr_en=%b want 0100/1", cs, wr_en); end
        tick();
        checks++; if (ack !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL mr_new_ack: got ack=%b err=%b want 1/0", ack, err); end
        req = 1'b0;
        tick();
        $display("reset mid-read: dropped, follow-up write to %h completed", addr);
    endtask

    task automatic test_req_drop();
        int a0, s0;
        a0 = ack_cnt; s0 = strobe_cnt;
        req = 1'b1; we = 1'b0; addr = 32'h0000_0000;
        tick();
        req = 1'b0; #1 req = 1'b1; #1 req = 1'b0;
        tick();
        checks++; if (ack !== 1'b0) begin fails++; $display("FAIL rq_early_ack: got %b want 0", ack); end
        tick();
        checks++; if (ack !== 1'b1 || rdd !== 32'h1234_5678) begin fails++; $display("FAIL rq_ack: got ack=%b data=%h want 1/12345678", ack, rdd); end
        tick(); tick(); tick();
        checks++; if (ack_cnt - a0 !== 1) begin fails++; $display("FAIL rq_ack_count: got %0d want 1", ack_cnt - a0); end
        checks++; if (strobe_cnt - s0 !== 1) begin fails++; $display("FAIL rq_strobe_count: got %0d want 1", strobe_cnt - s0); end
        $display("req dropped: read s0 acks=%0d strobes=%0d", ack_cnt - a0, strobe_cnt - s0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; fails = 0; ack_cnt = 0; strobe_cnt = 0;
        slave_val[0] = 32'h1234_5678;
        slave_val[1] = 32'h1111_1111;
        slave_val[2] = 32'hDEAD_BEEF;
        slave_val[3] = 32'hCAFE_0003;
        test_reset();
        test_write_led();
        test_read_slave2();
        test_unmapped();
        test_back_to_back();
        test_reset_mid_read();
        test_req_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
